// File: rtl/vector_floating_point_minmax_pipeline.sv
// Pipelined vector FP32/FP64 minimumNumber/maximumNumber unit with multi-beat reductions.
// Optional macro FP_MINMAX_FLAGS_EN enables sNaN detection driving out_fflags_nv.
module vector_floating_point_minmax_pipeline #(
   parameter  int NUM_LANES  = 2,
   parameter  int OP_WIDTH   = 2,
   localparam int DATA_WIDTH = 64 * NUM_LANES
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_WIDTH-1:0]   in_op,
   input  logic                  in_sew64,
   input  logic                  in_last,
   input  logic [DATA_WIDTH-1:0] vs2,
   input  logic [DATA_WIDTH-1:0] vs1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] vd,
   output logic                  out_fflags_nv
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   function automatic logic [31:0] sel32(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_max);
      logic a_nan, b_nan, a_lt_b;
      a_nan = (&a[30:23]) && (|a[22:0]);
      b_nan = (&b[30:23]) && (|b[22:0]);
      // Total order: sign first, then magnitude (reversed for negatives), so -0 < +0.
      if (a[31] != b[31]) a_lt_b = a[31];
      else if (a[31])     a_lt_b = a[30:0] > b[30:0];
      else                a_lt_b = a[30:0] < b[30:0];
      if (a_nan && b_nan) return 32'h7FC0_0000;
      if (a_nan)          return b;
      if (b_nan)          return a;
      return (a_lt_b ^ is_max) ? a : b;
   endfunction

   function automatic logic [63:0] sel64(input logic [63:0] a, input logic [63:0] b,
                                         input logic is_max);
      logic a_nan, b_nan, a_lt_b;
      a_nan = (&a[62:52]) && (|a[51:0]);
      b_nan = (&b[62:52]) && (|b[51:0]);
      if (a[63] != b[63]) a_lt_b = a[63];
      else if (a[63])     a_lt_b = a[62:0] > b[62:0];
      else                a_lt_b = a[62:0] < b[62:0];
      if (a_nan && b_nan) return 64'h7FF8_0000_0000_0000;
      if (a_nan)          return b;
      if (b_nan)          return a;
      return (a_lt_b ^ is_max) ? a : b;
   endfunction

`ifdef FP_MINMAX_FLAGS_EN
   function automatic logic snan32(input logic [31:0] a);
      return (&a[30:23]) && !a[22] && (|a[21:0]);
   endfunction

   function automatic logic snan64(input logic [63:0] a);
      return (&a[62:52]) && !a[51] && (|a[50:0]);
   endfunction
`endif

   state_t                state, state_next;
   logic                  out_valid_reg;
   logic [DATA_WIDTH-1:0] vd_reg;
   logic                  nv_reg;
   logic [63:0]           acc_reg;
   logic                  nv_acc_reg;
   logic                  sew_reg;
   logic                  max_reg;

   logic                  accept;
   logic                  ew_beat;
   logic [DATA_WIDTH-1:0] ew_vd;
   logic                  ew_nv;
   logic                  red_max;
   logic                  red_sew;
   logic [63:0]           acc_in;
   logic [63:0]           red_acc;
   logic                  red_nv;
   logic                  red_nv_total;
   logic [DATA_WIDTH-1:0] red_vd;

   assign in_ready      = (state != DRAIN) && (!out_valid_reg || out_ready);
   assign accept        = in_valid && in_ready;
   // Once a reduction is open, every beat belongs to it regardless of the op bits.
   assign ew_beat       = (state == IDLE) && !in_op[1];
   assign out_valid     = out_valid_reg;
   assign vd            = vd_reg;
   assign out_fflags_nv = nv_reg;

   // Elementwise datapath, one 64-bit lane per generate iteration.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic [63:0] a, b;
         assign a = vs2[gi*64 +: 64];
         assign b = vs1[gi*64 +: 64];
         assign ew_vd[gi*64 +: 64] = in_sew64 ? sel64(a, b, in_op[0])
                                              : {sel32(a[63:32], b[63:32], in_op[0]),
                                                 sel32(a[31:0],  b[31:0],  in_op[0])};
      end
   endgenerate

`ifdef FP_MINMAX_FLAGS_EN
   logic [NUM_LANES-1:0] lane_nv;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_nv
         logic [63:0] a, b;
         assign a = vs2[gi*64 +: 64];
         assign b = vs1[gi*64 +: 64];
         assign lane_nv[gi] = in_sew64 ? (snan64(a) | snan64(b))
                                       : (snan32(a[63:32]) | snan32(a[31:0]) |
                                          snan32(b[63:32]) | snan32(b[31:0]));
      end
   endgenerate
   assign ew_nv = |lane_nv;
`else
   assign ew_nv = 1'b0;
`endif

   // Reduction context: the first beat supplies op kind, width and seed.
   assign red_max = (state == IDLE) ? in_op[0] : max_reg;
   assign red_sew = (state == IDLE) ? in_sew64 : sew_reg;
   assign acc_in  = (state == IDLE) ? vs1[63:0] : acc_reg;

   // Balanced tree over the beat's elements, then folded into the accumulator.
   always_comb begin : red_tree
      logic [31:0] t32 [2*NUM_LANES];
      logic [63:0] t64 [NUM_LANES];
      for (int i = 0; i < 2*NUM_LANES; i++) t32[i] = vs2[i*32 +: 32];
      for (int i = 0; i < NUM_LANES; i++)   t64[i] = vs2[i*64 +: 64];
      for (int s = 1; s < 2*NUM_LANES; s = s * 2)
         for (int i = 0; i + s < 2*NUM_LANES; i = i + 2*s)
            t32[i] = sel32(t32[i], t32[i+s], red_max);
      for (int s = 1; s < NUM_LANES; s = s * 2)
         for (int i = 0; i + s < NUM_LANES; i = i + 2*s)
            t64[i] = sel64(t64[i], t64[i+s], red_max);
      red_acc = red_sew ? sel64(acc_in, t64[0], red_max)
                        : {32'h0, sel32(acc_in[31:0], t32[0], red_max)};
   end

`ifdef FP_MINMAX_FLAGS_EN
   // Accumulator values are never sNaN, so only the seed and vs2 elements matter.
   always_comb begin
      red_nv = red_sew ? snan64(acc_in) : snan32(acc_in[31:0]);
      for (int i = 0; i < 2*NUM_LANES; i++)
         if (!red_sew) red_nv = red_nv | snan32(vs2[i*32 +: 32]);
      for (int i = 0; i < NUM_LANES; i++)
         if (red_sew) red_nv = red_nv | snan64(vs2[i*64 +: 64]);
   end
`else
   assign red_nv = 1'b0;
`endif

   assign red_nv_total = ((state == IDLE) ? 1'b0 : nv_acc_reg) | red_nv;

   always_comb begin
      red_vd       = '0;
      red_vd[63:0] = red_acc;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && in_op[1]) state_next = in_last ? DRAIN : ACCUM;
         ACCUM:   if (accept && in_last)  state_next = DRAIN;
         DRAIN:   if (out_ready)          state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         vd_reg        <= '0;
         nv_reg        <= 1'b0;
         acc_reg       <= '0;
         nv_acc_reg    <= 1'b0;
         sew_reg       <= 1'b0;
         max_reg       <= 1'b0;
      end else begin
         if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
         if (accept) begin
            if (ew_beat) begin
               out_valid_reg <= 1'b1;
               vd_reg        <= ew_vd;
               nv_reg        <= ew_nv;
            end else begin
               acc_reg    <= red_acc;
               nv_acc_reg <= red_nv_total;
               if (state == IDLE) begin
                  sew_reg <= in_sew64;
                  max_reg <= in_op[0];
               end
               if (in_last) begin
                  out_valid_reg <= 1'b1;
                  vd_reg        <= red_vd;
                  nv_reg        <= red_nv_total;
               end
            end
         end
      end
   end

endmodule
